latch_axil_slave: RTL and testbench

- AXI4-Lite responder for the interlock latch register bank; the RTL end of the AXI4-Lite initiator traffic the block-design bench drives.
- Holds four 32-bit registers: CTRL, MASK, LATCH status and EVENT count.
- Samples external trigger lines, latches masked rising edges and drives the interlock output.
- Sits between the PS interconnect master port and the trigger/interlock fabric.

---
 rtl/latch_axil_slave.sv | 122 ++++++++++++
 tb/tb_latch_axil_slave.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_axil_slave.sv
// latch_axil_slave: AXI4-Lite interlock latch bank (CTRL, MASK, LATCH, COUNT) driving interlock_out.
// Optional: `define LATCH_AXIL_IRQ_EN adds irq output and IRQMASK register at 0x10.
module latch_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
`ifdef LATCH_AXIL_IRQ_EN
  parameter int C_S_AXI_ADDR_WIDTH = 5,
`else
  parameter int C_S_AXI_ADDR_WIDTH = 4,
`endif
  parameter int C_NUM_TRIG = 8
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [3:0]                      S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
`ifdef LATCH_AXIL_IRQ_EN
  output logic                            irq,
`endif
  input  logic [C_NUM_TRIG-1:0]           trig_in,
  output logic                            interlock_out
);
  logic r_awready, r_bvalid, r_arready, r_rvalid, r_il;
  logic [31:0] r_rdata, r_ctrl, r_count;
  logic [C_NUM_TRIG-1:0] r_mask, r_latch, r_sync1, r_sync2, r_prev;
  logic w_wen, w_ren, w_unused;
  logic [2:0] w_wsel, w_rsel;
  logic [31:0] w_bm, w_wd, w_ctrl_n, w_rd;
  logic [C_NUM_TRIG-1:0] w_mask_n, w_set, w_clr;
`ifdef LATCH_AXIL_IRQ_EN
  logic [C_NUM_TRIG-1:0] r_irqmask, w_irqmask_n;
  logic r_irq;
  assign irq = r_irq;
  assign w_irqmask_n = (r_irqmask & ~w_bm[C_NUM_TRIG-1:0]) | w_wd[C_NUM_TRIG-1:0];
  assign w_wsel = S_AXI_AWADDR[4:2];
  assign w_rsel = S_AXI_ARADDR[4:2];
`else
  assign w_wsel = {1'b0, S_AXI_AWADDR[3:2]};
  assign w_rsel = {1'b0, S_AXI_ARADDR[3:2]};
`endif
  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_awready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign interlock_out = r_il;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign w_wen = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
  assign w_ren = r_arready & S_AXI_ARVALID;
  assign w_bm = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}}, {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
  assign w_wd = S_AXI_WDATA & w_bm;
  assign w_ctrl_n = (r_ctrl & ~w_bm) | w_wd;
  assign w_mask_n = (r_mask & ~w_bm[C_NUM_TRIG-1:0]) | w_wd[C_NUM_TRIG-1:0];
  assign w_set = r_sync2 & ~r_prev & r_mask;
  // set is OR-ed in after the clear so a coincident trigger edge wins over W1C
  assign w_clr = (w_wen && w_wsel == 3'd2) ? w_wd[C_NUM_TRIG-1:0] : '0;
  always_comb begin
    w_rd = (w_rsel == 3'd0) ? r_ctrl : (w_rsel == 3'd1) ? 32'(r_mask) :
           (w_rsel == 3'd2) ? 32'(r_latch) : (w_rsel == 3'd3) ? r_count : '0;
`ifdef LATCH_AXIL_IRQ_EN
    if (w_rsel == 3'd4) w_rd = 32'(r_irqmask);
`endif
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_ctrl    <= '0;
      r_mask    <= '0;
      r_latch   <= '0;
      r_count   <= '0;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= '0;
      r_il      <= 1'b0;
`ifdef LATCH_AXIL_IRQ_EN
      r_irqmask <= '0;
      r_irq     <= 1'b0;
`endif
    end else begin
      r_awready <= S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid & ~r_awready;
      r_bvalid  <= w_wen | (r_bvalid & ~S_AXI_BREADY);
      r_arready <= S_AXI_ARVALID & ~r_rvalid & ~r_arready;
      r_rvalid  <= w_ren | (r_rvalid & ~S_AXI_RREADY);
      if (w_ren) r_rdata <= w_rd;
      r_sync1 <= trig_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_latch <= (r_latch & ~w_clr) | w_set;
      r_il    <= r_ctrl[0] & |r_latch;
      if (w_wen && w_wsel == 3'd0) r_ctrl <= w_ctrl_n;
      if (w_wen && w_wsel == 3'd1) r_mask <= w_mask_n;
      if (w_wen && w_wsel == 3'd3) r_count <= '0;
      else if (r_ctrl[1] && |(w_set & ~r_latch) && r_count != '1) r_count <= r_count + 1'b1;
`ifdef LATCH_AXIL_IRQ_EN
      if (w_wen && w_wsel == 3'd4) r_irqmask <= w_irqmask_n;
      r_irq <= r_ctrl[2] & |(r_latch & r_irqmask);
`endif
    end
endmodule

// File: tb/tb_latch_axil_slave.sv
// tb_latch_axil_slave: directed scenarios plus randomized traffic against a register-level model.
module tb_latch_axil_slave;
  localparam int NT = 8;
  localparam logic [31:0] NMASK = 32'h0000_00FF;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] awaddr = '0, araddr = '0, wstrb = '0;
  logic [31:0] wdata = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic awready, wready, bvalid, arready, rvalid, il;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [NT-1:0] trig = '0;
  int errs = 0, checks = 0;
  logic [31:0] m_ctrl, m_mask, m_latch, m_count;

  always #5 clk = ~clk;

  latch_axil_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .trig_in(trig), .interlock_out(il)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!awready && n < 20);
    checks++;
    if (!awready) begin errs++; $display("FAIL write_timeout addr=%h awready=%b required=1", a, awready); end
    tick();
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!arready && n < 20);
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    checks++;
    if (!rvalid) begin errs++; $display("FAIL read_timeout addr=%h rvalid=%b required=1", a, rvalid); end
    d = rdata;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, il} !== 6'b0) begin
      errs++; $display("FAIL reset_flags got=%b required=000000", {awready, wready, bvalid, arready, rvalid, il});
    end
    checks++;
    if (rdata !== 32'h0) begin errs++; $display("FAIL reset_rdata got=%h required=0", rdata); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_regmap();
    logic [31:0] exp [4];
    logic [31:0] d;
    exp[0] = 32'h1; exp[1] = 32'h2; exp[2] = 32'h0; exp[3] = 32'h0;
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d);
      checks++;
      if (d !== exp[i]) begin errs++; $display("FAIL regmap_%0d got=%h required=%h", i, d, exp[i]); end
    end
  endtask

  task automatic test_trigger();
    logic [31:0] d;
    axi_write(4'h0, 32'h3, 4'hF);
    axi_write(4'h4, 32'h5, 4'hF);
    axi_write(4'hC, 32'h0, 4'hF);
    trig = 8'h07;
    repeat (3) tick();
    checks++;
    if (il !== 1'b0) begin errs++; $display("FAIL interlock_early got=%b required=0", il); end
    tick();
    checks++;
    if (il !== 1'b1) begin errs++; $display("FAIL interlock_edge4 got=%b required=1", il); end
    trig = 8'h00;
    repeat (4) tick();
    axi_read(4'h8, d);
    checks++;
    if (d !== 32'h5) begin errs++; $display("FAIL trig_latch got=%h required=5", d); end
    axi_read(4'hC, d);
    checks++;
    if (d !== 32'h1) begin errs++; $display("FAIL trig_count got=%h required=1", d); end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d;
    trig = 8'h01;
    tick();
    awaddr = 4'h8; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    checks++;
    if (awready !== 1'b1) begin errs++; $display("FAIL collide_align awready=%b required=1", awready); end
    tick();
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    tick();
    bready = 1'b0;
    axi_read(4'h8, d);
    checks++;
    if (d !== 32'h5) begin errs++; $display("FAIL collide_set_wins got=%h required=5", d); end
    trig = 8'h00;
    repeat (4) tick();
    axi_write(4'h8, 32'h5, 4'hF);
    checks++;
    if (il !== 1'b0) begin errs++; $display("FAIL w1c_interlock got=%b required=0", il); end
    axi_read(4'h8, d);
    checks++;
    if (d !== 32'h0) begin errs++; $display("FAIL w1c_latch got=%h required=0", d); end
  endtask

  task automatic test_write_stall();
    int pulses;
    logic together;
    logic [31:0] d;
    awaddr = 4'h4; wdata = 32'h3C; wstrb = 4'hF; awvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (awready !== 1'b0 || wready !== 1'b0) begin
        errs++; $display("FAIL aw_only_%0d awready=%b wready=%b required=0", i, awready, wready);
      end
    end
    wvalid = 1'b1; pulses = 0; together = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (awready) pulses++;
      if (awready !== wready) together = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bvalid !== 1'b1 || awready !== 1'b0 || bresp !== 2'b00) begin
        errs++; $display("FAIL bstall_%0d bvalid=%b awready=%b bresp=%b required=1,0,00", i, bvalid, awready, bresp);
      end
      if (awready) pulses++;
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin errs++; $display("FAIL bvalid_release got=%b required=0", bvalid); end
    checks++;
    if (pulses != 1 || !together) begin
      errs++; $display("FAIL ready_pulse count=%0d together=%b required=1,1", pulses, together);
    end
    axi_read(4'h4, d);
    checks++;
    if (d !== 32'h3C) begin errs++; $display("FAIL stall_mask got=%h required=3c", d); end
  endtask

  task automatic test_read_stall();
    int n;
    axi_write(4'h4, 32'hA5A5_A5A5, 4'hF);
    araddr = 4'h4; arvalid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!arready && n < 20);
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'hA5 || arready !== 1'b0) begin
        errs++; $display("FAIL rstall_%0d rvalid=%b rdata=%h arready=%b required=1,000000a5,0", i, rvalid, rdata, arready);
      end
      tick();
    end
    rready = 1'b1; arvalid = 1'b0;
    tick();
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin errs++; $display("FAIL rvalid_release got=%b required=0", rvalid); end
  endtask

  task automatic test_reset_midtx();
    int n;
    logic [31:0] d;
    awaddr = 4'h0; wdata = 32'hFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!bvalid && n < 20);
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1) begin errs++; $display("FAIL pending_bvalid got=%b required=1", bvalid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bvalid !== 1'b0 || il !== 1'b0) begin
      errs++; $display("FAIL async_reset bvalid=%b il=%b required=0,0", bvalid, il);
    end
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (bvalid !== 1'b0) begin errs++; $display("FAIL no_resp_after_reset got=%b required=0", bvalid); end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d);
      checks++;
      if (d !== 32'h0) begin errs++; $display("FAIL post_reset_%0d got=%h required=0", i, d); end
    end
    m_ctrl = '0; m_mask = '0; m_latch = '0; m_count = '0;
  endtask

  task automatic test_random();
    logic [31:0] d, bm, exp, set;
    logic [NT-1:0] nt;
    logic [3:0] s;
    int a, op;
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 3);
      if (op == 0) begin
        nt = NT'($urandom);
        set = 32'(nt & ~trig) & m_mask;
        if (m_ctrl[1] && (set & ~m_latch) != 0 && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
        m_latch = m_latch | set;
        trig = nt;
        repeat (5) tick();
      end else if (op == 1) begin
        a = $urandom_range(0, 3); d = $urandom; s = 4'($urandom);
        for (int b = 0; b < 4; b++) bm[b*8 +: 8] = {8{s[b]}};
        if (a == 0) m_ctrl = (m_ctrl & ~bm) | (d & bm);
        else if (a == 1) m_mask = ((m_mask & ~bm) | (d & bm)) & NMASK;
        else if (a == 2) m_latch = m_latch & ~(d & bm);
        else m_count = 0;
        axi_write(4'(a * 4), d, s);
      end else begin
        a = $urandom_range(0, 3);
        exp = (a == 0) ? m_ctrl : (a == 1) ? m_mask : (a == 2) ? m_latch : m_count;
        axi_read(4'(a * 4), d);
        checks++;
        if (d !== exp) begin errs++; $display("FAIL rand_read_%0d addr=%h got=%h required=%h", i, a * 4, d, exp); end
      end
      checks++;
      if (il !== (m_ctrl[0] && m_latch != 0)) begin
        errs++; $display("FAIL rand_interlock_%0d got=%b required=%b", i, il, m_ctrl[0] && m_latch != 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_regmap();
    test_trigger();
    test_w1c_collision();
    test_write_stall();
    test_read_stall();
    test_reset_midtx();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
